// File: rtl/median_threshold_detector_if.sv
// ---------------------------------------------------------------------------
// median_threshold_detector_if
//
// Purpose: this interface groups the sample input stream (s_axis_a_*) and
// the detection output stream (m_axis_b_*) of median_threshold_detector.
//
// Handshake: s_axis_a_tvalid qualifies one beat per clock. There is no
// tready, and the detector accepts every cycle. m_axis_b_tvalid is a
// one-cycle detection strobe. m_axis_b_tchannel, m_axis_b_tdata and
// m_axis_b_tlast follow the input two cycles later whether or not the
// strobe is set.
//
// Modports:
//   slave  - the detector: samples s_axis_a_*, drives m_axis_b_*
//   master - the environment: drives s_axis_a_*, samples m_axis_b_*
//
// Optional: when MEDIAN_OUT_EN is defined, the interface adds
// m_axis_b_tmedian, the window median aligned with m_axis_b_tdata.
// ---------------------------------------------------------------------------
interface median_threshold_detector_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int CHANNEL_COUNT = 32,
    parameter int TIME_WIDTH    = 32
);
    localparam int CH_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;

    logic [CH_W-1:0]       s_axis_a_tchannel;
    logic [DATA_WIDTH-1:0] s_axis_a_tdata;
    logic                  s_axis_a_tvalid;
    logic                  s_axis_a_tlast;

    logic [TIME_WIDTH-1:0] m_axis_b_time;
    logic [CH_W-1:0]       m_axis_b_tchannel;
    logic [DATA_WIDTH-1:0] m_axis_b_tdata;
    logic                  m_axis_b_tvalid;
    logic                  m_axis_b_tlast;
`ifdef MEDIAN_OUT_EN
    logic [DATA_WIDTH-1:0] m_axis_b_tmedian;
`endif

    modport slave (
        input  s_axis_a_tchannel, s_axis_a_tdata, s_axis_a_tvalid, s_axis_a_tlast,
`ifdef MEDIAN_OUT_EN
        output m_axis_b_tmedian,
`endif
        output m_axis_b_time, m_axis_b_tchannel, m_axis_b_tdata, m_axis_b_tvalid,
        output m_axis_b_tlast
    );

    modport master (
        output s_axis_a_tchannel, s_axis_a_tdata, s_axis_a_tvalid, s_axis_a_tlast,
`ifdef MEDIAN_OUT_EN
        input  m_axis_b_tmedian,
`endif
        input  m_axis_b_time, m_axis_b_tchannel, m_axis_b_tdata, m_axis_b_tvalid,
        input  m_axis_b_tlast
    );
endinterface

// File: rtl/median_threshold_detector.sv
// ---------------------------------------------------------------------------
// median_threshold_detector
//
// Purpose: this is a per-channel running-median spike detector for
// channel-interleaved unsigned samples. Each channel keeps a window of the
// last WINDOW_LENGTH samples in block RAM. The window is sorted by value,
// and each slot carries an age tag. A sample is flagged when it exceeds the
// scaled window median and the absolute floor ABS_THR. The window must also
// be full, and the channel must be out of its refractory holdoff.
//
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - median_threshold_detector_if.slave
//           (s_axis_a_* in, m_axis_b_* out, fixed 2-cycle latency)
//
// Pipeline:
//   S0: the RAM is read at the input channel.
//   S1: the window is forwarded or taken from RAM, then updated and
//       written back, and the detect decision is made.
//   S2: the outputs are registered.
//
// Optional: define MEDIAN_OUT_EN to expose m_axis_b_tmedian.
// ---------------------------------------------------------------------------
module median_threshold_detector #(
    parameter int DATA_WIDTH      = 16,
    parameter int CHANNEL_COUNT   = 32,
    parameter int WINDOW_LENGTH   = 15,
    parameter int TIME_WIDTH      = 32,
    parameter int THR_MULT        = 32,
    parameter int THR_SHIFT       = 0,
    parameter int ABS_THR         = 32,
    parameter int REFRACT_SAMPLES = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    median_threshold_detector_if.slave  bus
);
    localparam int CH_W   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int AGE_W  = $clog2(WINDOW_LENGTH + 1);
    localparam int SLOT_W = DATA_WIDTH + AGE_W;
    localparam int WIN_W  = WINDOW_LENGTH * SLOT_W;
    localparam int MID    = WINDOW_LENGTH / 2;
    localparam int PROD_W = DATA_WIDTH + THR_SHIFT + $clog2(THR_MULT + 1);
    localparam int RF_W   = (REFRACT_SAMPLES > 0) ? $clog2(REFRACT_SAMPLES + 1) : 1;

    // Window RAM: slot i sits at bits [i*SLOT_W +: SLOT_W] as {value, age}.
    logic [WIN_W-1:0]      mem [CHANNEL_COUNT];
    logic [WIN_W-1:0]      rd_q;

    logic                  s1_valid, s1_last;
    logic [CH_W-1:0]       s1_ch;
    logic [DATA_WIDTH-1:0] s1_data;

    // fw1 is the window written one cycle ago; fw2 is the one written two
    // cycles ago.
    logic                  fw1_valid, fw2_valid;
    logic [CH_W-1:0]       fw1_ch, fw2_ch;
    logic [WIN_W-1:0]      fw1_win, fw2_win;

    logic [AGE_W-1:0]      fill_q [CHANNEL_COUNT];
    logic [RF_W-1:0]       refr_q [CHANNEL_COUNT];
    logic [TIME_WIDTH-1:0] time_q;

    logic [WIN_W-1:0]      cur_win, new_win;
    logic [DATA_WIDTH-1:0] r_val [WINDOW_LENGTH];
    logic [DATA_WIDTH-1:0] c_val [WINDOW_LENGTH];
    logic [DATA_WIDTH-1:0] n_val [WINDOW_LENGTH];
    logic [AGE_W-1:0]      r_age [WINDOW_LENGTH];
    logic [AGE_W-1:0]      c_age [WINDOW_LENGTH];
    logic [AGE_W-1:0]      n_age [WINDOW_LENGTH];
    logic [AGE_W-1:0]      cur_fill, new_fill, ev_idx, keep_cnt, ins_pos;
    logic [RF_W-1:0]       cur_refr;
    logic                  full_before;
    logic [DATA_WIDTH-1:0] median;
    logic [PROD_W-1:0]     lhs, rhs;
    logic                  detect;

    always_comb begin
        // The source window comes from RAM unless a same-channel write is
        // still in flight. Distance 1 is checked last so that it wins.
        cur_win = rd_q;
        if (fw2_valid && fw2_ch == s1_ch) cur_win = fw2_win;
        if (fw1_valid && fw1_ch == s1_ch) cur_win = fw1_win;

        cur_fill    = fill_q[s1_ch];
        cur_refr    = refr_q[s1_ch];
        full_before = (cur_fill == AGE_W'(WINDOW_LENGTH));

        for (int i = 0; i < WINDOW_LENGTH; i++) begin
            r_age[i] = cur_win[i*SLOT_W +: AGE_W];
            r_val[i] = cur_win[i*SLOT_W + AGE_W +: DATA_WIDTH];
        end

        // The oldest sample, age 1, leaves only when the window is full.
        // ev_idx = WINDOW_LENGTH means nothing is evicted.
        ev_idx = AGE_W'(WINDOW_LENGTH);
        for (int i = 0; i < WINDOW_LENGTH; i++)
            if (full_before && r_age[i] == AGE_W'(1)) ev_idx = AGE_W'(i);
        keep_cnt = full_before ? AGE_W'(WINDOW_LENGTH - 1) : cur_fill;

        // Close the gap left by eviction and age the survivors. The slots
        // beyond keep_cnt hold stale data, and nothing reads them below.
        for (int i = 0; i < WINDOW_LENGTH; i++) begin
            if (AGE_W'(i) < ev_idx) begin
                c_val[i] = r_val[i];
                c_age[i] = r_age[i] - AGE_W'(1);
            end else begin
                c_val[i] = r_val[(i + 1 < WINDOW_LENGTH) ? i + 1 : i];
                c_age[i] = r_age[(i + 1 < WINDOW_LENGTH) ? i + 1 : i] - AGE_W'(1);
            end
        end

        // The insert position counts occupied slots <= sample, so equal
        // values stay ahead of the new sample. Unoccupied slots act as +inf.
        ins_pos = '0;
        for (int i = 0; i < WINDOW_LENGTH; i++)
            if (AGE_W'(i) < keep_cnt && c_val[i] <= s1_data) ins_pos = ins_pos + AGE_W'(1);

        new_win = '0;
        for (int i = 0; i < WINDOW_LENGTH; i++) begin
            if (AGE_W'(i) < ins_pos) begin
                n_val[i] = c_val[i];
                n_age[i] = c_age[i];
            end else if (AGE_W'(i) == ins_pos) begin
                n_val[i] = s1_data;
                n_age[i] = AGE_W'(WINDOW_LENGTH);
            end else begin
                n_val[i] = c_val[(i > 0) ? i - 1 : 0];
                n_age[i] = c_age[(i > 0) ? i - 1 : 0];
            end
            new_win[i*SLOT_W +: SLOT_W] = {n_val[i], n_age[i]};
        end

        new_fill = full_before ? cur_fill : cur_fill + AGE_W'(1);
        median   = n_val[MID];

        // Both sides are widened first so the shift and the multiply keep
        // every bit.
        lhs    = PROD_W'(s1_data) << THR_SHIFT;
        rhs    = PROD_W'(median) * PROD_W'(THR_MULT);
        detect = s1_valid && (new_fill == AGE_W'(WINDOW_LENGTH)) && (lhs > rhs)
                 && (s1_data > DATA_WIDTH'(ABS_THR)) && (cur_refr == '0);
    end

    // Block RAM and forwarding data paths. They have no reset, because the
    // fill counters decide which contents count. No write is allowed during
    // reset, so an in-flight beat cannot leave a partial update behind.
    always_ff @(posedge clk) begin
        rd_q    <= mem[bus.s_axis_a_tchannel];
        fw1_win <= new_win;
        fw2_win <= fw1_win;
        if (rst_n && s1_valid) mem[s1_ch] <= new_win;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid              <= 1'b0;
            s1_last               <= 1'b0;
            s1_ch                 <= '0;
            s1_data               <= '0;
            fw1_valid             <= 1'b0;
            fw2_valid             <= 1'b0;
            fw1_ch                <= '0;
            fw2_ch                <= '0;
            time_q                <= '0;
            bus.m_axis_b_time     <= '0;
            bus.m_axis_b_tchannel <= '0;
            bus.m_axis_b_tdata    <= '0;
            bus.m_axis_b_tvalid   <= 1'b0;
            bus.m_axis_b_tlast    <= 1'b0;
`ifdef MEDIAN_OUT_EN
            bus.m_axis_b_tmedian  <= '0;
`endif
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
                fill_q[c] <= '0;
                refr_q[c] <= '0;
            end
        end else begin
            s1_valid  <= bus.s_axis_a_tvalid;
            s1_last   <= bus.s_axis_a_tlast;
            s1_ch     <= bus.s_axis_a_tchannel;
            s1_data   <= bus.s_axis_a_tdata;
            fw1_valid <= s1_valid;
            fw1_ch    <= s1_ch;
            fw2_valid <= fw1_valid;
            fw2_ch    <= fw1_ch;

            bus.m_axis_b_time     <= time_q;
            bus.m_axis_b_tchannel <= s1_ch;
            bus.m_axis_b_tdata    <= s1_data;
            bus.m_axis_b_tvalid   <= detect;
            bus.m_axis_b_tlast    <= s1_last;
`ifdef MEDIAN_OUT_EN
            bus.m_axis_b_tmedian  <= (s1_valid && new_fill == AGE_W'(WINDOW_LENGTH)) ? median : '0;
`endif
            if (s1_valid) begin
                fill_q[s1_ch] <= new_fill;
                if (detect)
                    refr_q[s1_ch] <= RF_W'(REFRACT_SAMPLES);
                else if (cur_refr != '0)
                    refr_q[s1_ch] <= cur_refr - RF_W'(1);
                if (s1_last) time_q <= time_q + TIME_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_median_threshold_detector.sv
`timescale 1ns/1ps
module tb_median_threshold_detector;
    localparam int DW    = 16;
    localparam int CH    = 4;
    localparam int CW    = 2;
    localparam int WL    = 5;
    localparam int TW    = 32;
    localparam int MULT  = 4;
    localparam int SHIFT = 0;
    localparam int ABS   = 10;
    localparam int REFR  = 2;
    // Record layout: {time, channel(8), data, tvalid, tlast, median}
    localparam int W     = TW + 8 + DW + 1 + 1 + DW;
`ifdef MEDIAN_OUT_EN
    localparam bit MED_EN = 1'b1;
`else
    localparam bit MED_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    median_threshold_detector_if #(.DATA_WIDTH(DW), .CHANNEL_COUNT(CH), .TIME_WIDTH(TW)) bus ();

    median_threshold_detector #(
        .DATA_WIDTH(DW), .CHANNEL_COUNT(CH), .WINDOW_LENGTH(WL), .TIME_WIDTH(TW),
        .THR_MULT(MULT), .THR_SHIFT(SHIFT), .ABS_THR(ABS), .REFRACT_SAMPLES(REFR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            hist [CH][WL];   // last WL samples per channel, ring order
    int            wp   [CH];
    int            fill [CH];
    int            refr [CH];
    logic [TW-1:0] mtime;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            wp[c] = 0;
            fill[c] = 0;
            refr[c] = 0;
        end
        mtime = '0;
        exp_q.delete();
        // Reset-cleared S1 contents, then the idle beat presented during reset release
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic model_beat(input int ch, input int data, input bit valid, input bit last);
        int srt [WL];
        int med;
        int t;
        bit det;
        med = 0;
        det = 1'b0;
        if (valid) begin
            hist[ch][wp[ch]] = data;
            wp[ch] = (wp[ch] + 1) % WL;
            if (fill[ch] < WL) fill[ch]++;
            if (fill[ch] == WL) begin
                for (int i = 0; i < WL; i++) srt[i] = hist[ch][i];
                for (int i = 0; i < WL - 1; i++)
                    for (int j = 0; j < WL - 1 - i; j++)
                        if (srt[j] > srt[j+1]) begin
                            t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t;
                        end
                med = srt[WL/2];
                det = ((longint'(data) << SHIFT) > longint'(med) * MULT) && (data > ABS) && (refr[ch] == 0);
            end
            if (det) refr[ch] = REFR;
            else if (refr[ch] > 0) refr[ch]--;
        end
        exp_q.push_back({mtime, 8'(ch), DW'(data), det, last, (MED_EN ? DW'(med) : DW'(0))});
        if (valid && last) mtime = mtime + 1;
    endtask

    function automatic logic [W-1:0] observed();
        logic [DW-1:0] m;
        m = '0;
`ifdef MEDIAN_OUT_EN
        m = bus.m_axis_b_tmedian;
`endif
        return {bus.m_axis_b_time, 8'(bus.m_axis_b_tchannel), bus.m_axis_b_tdata,
                bus.m_axis_b_tvalid, bus.m_axis_b_tlast, m};
    endfunction

    task automatic check_out(input string tag);
        logic [W-1:0] o;
        logic [W-1:0] e;
        o = observed();
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got {time,ch,data,vld,last,med}=%h expected %h", tag, o, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int ch, input int data, input bit valid, input bit last, input string tag);
        @(negedge clk);
        check_out(tag);
        bus.s_axis_a_tchannel = CW'(ch);
        bus.s_axis_a_tdata    = DW'(data);
        bus.s_axis_a_tvalid   = valid;
        bus.s_axis_a_tlast    = last;
        model_beat(ch, data, valid, last);
    endtask

    task automatic frame(input int sel, input int val, input int filler, input string tag);
        for (int c = 0; c < CH; c++)
            send(c, (c == sel) ? val : filler, 1'b1, c == CH - 1, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_axis_a_tchannel = '0;
        bus.s_axis_a_tdata    = '0;
        bus.s_axis_a_tvalid   = 1'b0;
        bus.s_axis_a_tlast    = 1'b0;
        @(negedge clk);
        checks++;
        assert (observed() === '0) else begin
            errors++;
            $error("FAIL reset_state: got %h expected 0", observed());
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // Looks at the outputs currently on the bus, i.e. the beat two sends back
    task automatic expect_out(input string tag, input int ch, input int data, input bit valid, input int t);
        checks++;
        assert (bus.m_axis_b_tvalid === valid && bus.m_axis_b_tdata === DW'(data) &&
                bus.m_axis_b_tchannel === CW'(ch) && bus.m_axis_b_time === TW'(t)) else begin
            errors++;
            $error("FAIL %s: got ch=%0d data=%0d vld=%0b time=%0d expected ch=%0d data=%0d vld=%0b time=%0d",
                   tag, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tvalid, bus.m_axis_b_time,
                   ch, data, valid, t);
        end
    endtask

    int ev_seq [10] = '{5, 5, 5, 5, 5, 1, 1, 1, 9, 11};
    int fw_seq [6]  = '{1, 2, 3, 4, 5, 50};

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.s_axis_a_tchannel = '0;
        bus.s_axis_a_tdata    = '0;
        bus.s_axis_a_tvalid   = 1'b0;
        bus.s_axis_a_tlast    = 1'b0;

        // Warm-up: channel 0 sees 2,2,2,2 and then a spike in frame 4
        do_reset();
        for (int k = 0; k < 4; k++) frame(0, 2, 1, "warmup");
        send(0, 200, 1'b1, 1'b0, "warmup");
        send(1, 1, 1'b1, 1'b0, "warmup");
        send(2, 1, 1'b1, 1'b0, "warmup");
        expect_out("warmup_spike", 0, 200, 1'b1, 4);
        send(3, 1, 1'b1, 1'b1, "warmup");

        // Eviction: the median on channel 1 drops, 9 fails ABS_THR and 11 detects
        do_reset();
        for (int k = 0; k < 10; k++) frame(1, ev_seq[k], 0, "evict");
        expect_out("evict_eleven", 1, 11, 1'b1, 9);

        // Refractory: a run of 100s on channel 2 after a window of 3s
        do_reset();
        for (int k = 0; k < 5; k++) frame(2, 3, 0, "refract_fill");
        for (int k = 0; k < 4; k++) frame(2, 100, 0, "refract_run");

        // Forwarding: back-to-back beats on one channel, then distance-2 interleave
        do_reset();
        for (int k = 0; k < 6; k++) send(0, fw_seq[k], 1'b1, 1'b0, "fwd_d1");
        send(0, 0, 1'b0, 1'b0, "fwd_d1");
        send(0, 0, 1'b0, 1'b0, "fwd_d1");
        expect_out("fwd_spike", 0, 50, 1'b1, 0);
        for (int k = 0; k < 12; k++)
            send(k % 2, (k % 5 == 4) ? 90 : k + 1, 1'b1, 1'b0, "fwd_d2");

        // Timestamp: three frames and then a reset in the middle of a frame
        do_reset();
        for (int k = 0; k < 3; k++) frame(-1, 2, 2, "time");
        expect_out("time_frame2", 1, 2, 1'b0, 2);
        send(0, 7, 1'b1, 1'b0, "mid_reset");
        send(1, 7, 1'b1, 1'b0, "mid_reset");
        do_reset();
        for (int k = 0; k < 5; k++) frame(0, (k == 4) ? 60 : 1, 1, "refill");

        // Random traffic: arbitrary channel order, gaps and occasional spikes
        for (int k = 0; k < 800; k++) begin
            int ch;
            int d;
            ch = $urandom_range(0, CH - 1);
            d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 30);
            send(ch, d, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, "random");
        end

        send(0, 0, 1'b0, 1'b0, "drain");
        send(0, 0, 1'b0, 1'b0, "drain");
        send(0, 0, 1'b0, 1'b0, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
